// File: rtl/perceptron_core.sv
// perceptron_core: sequencing/compute stage downstream of the weight memory.
// On start it reads all N_W Q6.9 weights over the memory port, forms the dot
// product with the latched input vector (x[0] is an implicit bias of 1.0),
// applies a step activation and, when training with a wrong answer, writes
// perceptron-rule updates back over the same port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start/train/target  begin a pass; train/target/x_vec latched with start
//   x_vec               packed Q6.9 inputs, x[i] = x_vec[16*i-1 -: 16]
//   mem_ena/wr_rd/addr  weight memory control (wr_rd: 1 = write)
//   mem_wdata/mem_rdata weight memory data (read data valid one cycle later)
//   busy/done/updated   pass status; done is a one-cycle pulse
//   y/sum               activation and Q6.9 dot product, held until next pass
//
// Build option: define PERCEPTRON_SAT_EN to saturate sum and weight write-back
// to the 16-bit signed range instead of wrapping.
module perceptron_core #(
  parameter int N_W   = 3,
  parameter int LR_Q9 = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  train,
  input  logic                  target,
  input  logic [16*(N_W-1)-1:0] x_vec,
  output logic                  mem_ena,
  output logic                  wr_rd,
  output logic [5:0]            addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  y,
  output logic [15:0]           sum,
  output logic                  updated
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_ACT  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [5:0] LAST_IDX = 6'(N_W - 1);
  localparam logic [8:0] LR9      = 9'(LR_Q9);

  logic [2:0]            state;
  logic [5:0]            idx;
  logic signed [37:0]    acc;
  logic signed [15:0]    wcache [N_W];
  logic [16*(N_W-1)-1:0] x_q;
  logic                  train_q;
  logic                  target_q;
  logic                  wrote;
  logic                  y_q;
  logic [15:0]           sum_q;

  // Unpacked view of the input vector with the bias term in slot 0.
  logic signed [15:0]    x_arr [N_W];

  assign x_arr[0] = 16'sd512;
  for (genvar g = 1; g < N_W; g++) begin : g_x
    assign x_arr[g] = x_q[16*g-1 -: 16];
  end

  // Accumulate path: read data lags the issued address by one cycle, so the
  // weight arriving now belongs to idx-1 (or to the last index in LAST).
  logic               acc_en;
  logic [5:0]         acc_idx;
  logic signed [31:0] prod;
  logic signed [37:0] acc_sum;

  always_comb begin
    acc_en  = ((state == S_RD) && (idx != '0)) || (state == S_LAST);
    acc_idx = (state == S_LAST) ? LAST_IDX : (idx - 6'd1);
    prod    = 32'($signed(mem_rdata)) * 32'(x_arr[acc_idx]);
    acc_sum = acc + $signed({{6{prod[31]}}, prod});
  end

  // Activation path.
  logic signed [37:0] acc_sh;
  logic [15:0]        sum_next;
  logic               y_next;

  always_comb begin
    acc_sh = acc >>> 9;
`ifdef PERCEPTRON_SAT_EN
    if (acc_sh > 38'sd32767)
      sum_next = 16'h7fff;
    else if (acc_sh < -38'sd32768)
      sum_next = 16'h8000;
    else
      sum_next = acc_sh[15:0];
`else
    sum_next = acc_sh[15:0];
`endif
    y_next = ~acc[37];
  end

  // Write-back path: err is +1 exactly when target is 1 (WR only runs on a
  // wrong answer), so target_q selects add versus subtract.
  logic signed [25:0] lr_prod;
  logic signed [25:0] lr_sh;
  logic signed [15:0] delta;
  logic signed [16:0] w_sum;
  logic [15:0]        w_new;

  always_comb begin
    lr_prod = 26'($signed({1'b0, LR9})) * 26'(x_arr[idx]);
    lr_sh   = lr_prod >>> 9;
    delta   = lr_sh[15:0];
    w_sum   = target_q ? (17'(wcache[idx]) + 17'(delta))
                       : (17'(wcache[idx]) - 17'(delta));
`ifdef PERCEPTRON_SAT_EN
    if (w_sum[16] != w_sum[15])
      w_new = w_sum[16] ? 16'h8000 : 16'h7fff;
    else
      w_new = w_sum[15:0];
`else
    w_new = w_sum[15:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      acc      <= '0;
      x_q      <= '0;
      train_q  <= 1'b0;
      target_q <= 1'b0;
      wrote    <= 1'b0;
      y_q      <= 1'b0;
      sum_q    <= '0;
      for (int unsigned i = 0; i < N_W; i++) wcache[i] <= '0;
    end else begin
      if (acc_en) begin
        acc             <= acc_sum;
        wcache[acc_idx] <= mem_rdata;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            train_q  <= train;
            target_q <= target;
            x_q      <= x_vec;
            acc      <= '0;
            idx      <= '0;
            wrote    <= 1'b0;
            state    <= S_RD;
          end
        end
        S_RD: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= S_LAST;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        S_LAST: state <= S_ACT;
        S_ACT: begin
          sum_q <= sum_next;
          y_q   <= y_next;
          if (train_q && (y_next != target_q)) begin
            wrote <= 1'b1;
            state <= S_WR;
          end else begin
            state <= S_DONE;
          end
        end
        S_WR: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_ena   = (state == S_RD) || (state == S_WR);
  assign wr_rd     = (state == S_WR);
  assign addr      = mem_ena ? idx : '0;
  assign mem_wdata = (state == S_WR) ? w_new : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign updated   = done & wrote;
  assign y         = y_q;
  assign sum       = sum_q;

endmodule

// File: doc/perceptron_core.md
Name: perceptron_core

Overview:
- Compute/sequencing stage that sits directly downstream of the 3-entry weight memory.
- The weight memory is 16-bit signed Q6.9, where 1.0 = 512, with a registered read port.
- On start, this block:
  - reads all weights through the memory port,
  - forms the dot product with a latched input vector plus an implicit bias input of 1.0,
  - applies a step activation,
  - optionally writes perceptron-rule weight updates back through the same port.

Parameters:
- N_W, 3: number of weights; index 0 is the bias. Legal range 2..64.
- LR_Q9, 64: learning rate in Q.9 (64 = 0.125), unsigned, 0..511.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one evaluation; sampled only in IDLE
- train  in  1  enable weight update; latched with start
- target  in  1  desired output 0/1; latched with start
- x_vec  in  16*(N_W-1)  signed Q6.9 inputs; x[i] = x_vec[16*i-1 -: 16] for i = 1..N_W-1; latched with start
- mem_ena  out  1  weight memory enable
- wr_rd  out  1  1 = write, 0 = read
- addr  out  6  weight index
- mem_wdata  out  16  write data to weight memory
- mem_rdata  in  16  weight memory read data, valid the cycle after a read is issued
- busy  out  1  high from the cycle after start acceptance until DONE completes
- done  out  1  one-cycle pulse
- y  out  1  activation result; held until the next ACT
- sum  out  16  dot product in Q6.9; held until the next ACT
- updated  out  1  high with done if weights were written

Behaviour:
- Reset:
  - Async assert forces IDLE immediately.
  - mem_ena, wr_rd, addr, mem_wdata, busy, done, y, updated and sum all go to 0.
  - Internal accumulator and counters are cleared.
  - Reset mid-operation abandons the pass. A partial write sequence may leave memory partly updated; this is accepted.
- Inputs:
  - x[0] is the constant 512.
  - start is ignored while busy; no queuing.
- States:
  - IDLE:
    - start=1 latches train, target, x_vec; clears acc and idx.
    - Next state is RD.
  - RD:
    - Drives mem_ena=1, wr_rd=0, addr=idx for N_W consecutive cycles, idx = 0..N_W-1.
    - Each cycle, the mem_rdata returned for the previous idx is stored in wcache[idx-1] and multiplied by x[idx-1]; the 32-bit signed product is added to acc.
    - acc width is 32 + 6 bits.
    - After idx = N_W-1 is issued, go to LAST.
  - LAST:
    - mem_ena=0.
    - Captures the final weight into wcache and does the final accumulate.
  - ACT:
    - sum = acc >>> 9, truncated to 16 bits (see the optional feature for saturation).
    - y = 1 if acc >= 0, else 0 (zero maps to 1).
    - err = target - y.
    - If train=1 and err != 0, go to WR; otherwise go to DONE.
  - WR, N_W cycles, idx = 0..N_W-1:
    - mem_ena=1, wr_rd=1, addr=idx.
    - delta = (LR_Q9 * x[idx]) >>> 9, signed 16-bit result.
    - mem_wdata = wcache[idx] + delta when err = +1, wcache[idx] - delta when err = -1; arithmetic is 17-bit, then reduced to 16.
    - Then go to DONE.
  - DONE:
    - done=1 for one cycle; updated=1 if WR was visited.
    - busy falls at the end of this cycle. Return to IDLE.
- Latency, with start sampled on edge 0:
  - done is high in cycle N_W+3 without update (6 for N_W = 3).
  - done is high in cycle 2*N_W+3 with update (9 for N_W = 3).
  - A new start is accepted in the cycle after done.
- mem_ena is 0 in IDLE, LAST, ACT and DONE.

Optional Feature:
- Macro: PERCEPTRON_SAT_EN.
- Defined:
  - sum saturates to [-32768, 32767] when acc >>> 9 is out of range.
  - Weight write-back saturates to the same range.
- Undefined: both are plain two's-complement truncation (wrap).

Test Plan:
- Inference:
  - Setup: memory w = {256, 512, -512}; x1 = 512, x2 = 128; start with train=0.
  - Required: reads at addr 0, 1, 2 in cycles 1-3; done in cycle 6; sum = 640; y = 1; updated = 0; no writes.
- Training with error:
  - Setup: same as inference, but train=1, target=0.
  - Required: writes in cycles 6-8 to addr 0 ← 192, addr 1 ← 448, addr 2 ← -528.
  - Required: done in cycle 9; updated = 1.
- Training, no error and boundary:
  - train=1, target=1 on the same data → no write cycles; done in cycle 6.
  - Weights all 0 → sum = 0, y = 1.
- Saturation:
  - Setup: w = {32700, 0, 0}, target=1, y=0 forced by w2 = -32768 with x2 = 512.
  - Bias write with PERCEPTRON_SAT_EN defined → 32764 (no overflow case).
  - Repeat with w0 = 32760, LR_Q9 = 511:
    - With PERCEPTRON_SAT_EN → 32767.
    - Without it → wraps negative, -32265.
- Protocol:
  - start pulsed in cycles 2-4 while busy is ignored (single done).
  - Back-to-back start in the cycle after done is accepted.
- Reset:
  - rst_n low in cycle 7 of a training pass → mem_ena, busy, done drop immediately.
  - After release, a fresh start produces the correct done timing.
